// File: rtl/sdram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_arbiter: round-robin sharing of one as4c4m16sa SDRAM controller.
// Rev 1.0
// ----------------------------------------------------------------------------
module sdram_arbiter #(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int SETTLE_CYCLES  = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [2*NUM_PORTS-1:0]    req_command,
    input  logic [22*NUM_PORTS-1:0]   req_address,
    input  logic [16*NUM_PORTS-1:0]   req_write_data,
    output logic [NUM_PORTS-1:0]      grant,
    output logic [NUM_PORTS-1:0]      wr_advance,
    output logic [NUM_PORTS-1:0]      rd_valid,
    output logic [15:0]               rd_data,
    output logic [NUM_PORTS-1:0]      op_done,
    output logic [NUM_PORTS-1:0]      op_error,
    output logic [1:0]                ctrl_command,
    output logic [21:0]               ctrl_address,
    output logic [15:0]               ctrl_write_data,
    input  logic [15:0]               ctrl_data_read,
    input  logic                      ctrl_data_read_valid,
    input  logic                      ctrl_data_write_done
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_SETTLE  = 3'd0,
        S_IDLE    = 3'd1,
        S_ISSUE   = 3'd2,
        S_BURST   = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_owner;
    logic                  r_is_write;
    logic [TW-1:0]         r_tmo;
    logic [SW-1:0]         r_quiet;

    logic                  w_any_beat;
    logic                  w_first_beat;
    logic                  w_timeout;
    logic [NUM_PORTS-1:0]  w_req;
    logic                  w_found;
    logic [PW-1:0]         w_pick;
    logic [1:0]            w_pick_cmd;
    logic [21:0]           w_pick_addr;
    logic [NUM_PORTS-1:0]  w_pick_onehot;

    assign w_any_beat   = ctrl_data_read_valid | ctrl_data_write_done;
    assign w_first_beat = r_is_write ? ctrl_data_write_done : ctrl_data_read_valid;
    assign w_timeout    = ((r_state == S_ISSUE) || (r_state == S_BURST)) &&
                          (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    // Commands 1 (write) and 2 (read) request; 0 and 3 are idle.
    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req
            assign w_req[i] = req_command[2*i] ^ req_command[2*i+1];
        end
    endgenerate

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            if (!w_found && w_req[(int'(r_ptr) + k) % NUM_PORTS]) begin
                w_found = 1'b1;
                w_pick  = PW'((int'(r_ptr) + k) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        w_pick_cmd    = '0;
        w_pick_addr   = '0;
        w_pick_onehot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_pick == PW'(i)) begin
                w_pick_cmd       = req_command[2*i +: 2];
                w_pick_addr      = req_address[22*i +: 22];
                w_pick_onehot[i] = 1'b1;
            end
        end
    end

    // Write data stays live so burst words follow the requester beat by beat.
    always_comb begin
        ctrl_write_data = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                ctrl_write_data = req_write_data[16*i +: 16];
            end
        end
    end

    assign rd_valid   = grant & {NUM_PORTS{ctrl_data_read_valid}};
    assign wr_advance = grant & {NUM_PORTS{ctrl_data_write_done}};
    assign rd_data    = ctrl_data_read;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_SETTLE;
            r_ptr        <= PW'(NUM_PORTS - 1);
            r_owner      <= '0;
            r_is_write   <= 1'b0;
            r_tmo        <= '0;
            r_quiet      <= '0;
            grant        <= '0;
            op_done      <= '0;
            op_error     <= '0;
            ctrl_command <= '0;
            ctrl_address <= '0;
        end else begin
            op_done  <= '0;
            op_error <= '0;
            if (w_timeout) begin
                ctrl_command <= '0;
                op_done      <= grant;
                op_error     <= grant;
                grant        <= '0;
                r_ptr        <= r_owner;
                r_quiet      <= '0;
                r_state      <= S_SETTLE;
            end else begin
                case (r_state)
                    S_SETTLE: begin
                        if (w_any_beat) begin
                            r_quiet <= '0;
                        end else if (r_quiet == SW'(SETTLE_CYCLES - 1)) begin
                            r_quiet <= '0;
                            r_state <= S_IDLE;
                        end else begin
                            r_quiet <= r_quiet + 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (w_found) begin
                            grant        <= w_pick_onehot;
                            ctrl_command <= w_pick_cmd;
                            ctrl_address <= w_pick_addr;
                            r_is_write   <= (w_pick_cmd == 2'd1);
                            r_owner      <= w_pick;
                            r_tmo        <= '0;
                            r_state      <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        r_tmo <= r_tmo + 1'b1;
                        // Dropping the command here stops a re-issue once the controller idles.
                        if (w_first_beat) begin
                            ctrl_command <= '0;
                            r_state      <= S_BURST;
                        end
                    end
                    S_BURST: begin
                        r_tmo <= r_tmo + 1'b1;
                        if (!w_any_beat) begin
                            r_state <= S_RELEASE;
                        end
                    end
                    S_RELEASE: begin
                        op_done <= grant;
                        grant   <= '0;
                        r_ptr   <= r_owner;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_SETTLE;
                endcase
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sdram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_sdram_arbiter: directed vectors against a small SDRAM controller model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_sdram_arbiter;
    localparam int N = 4;
    localparam int T = 4096;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [2*N-1:0]    req_command;
    logic [22*N-1:0]   req_address;
    logic [16*N-1:0]   req_write_data;
    logic [N-1:0]      grant, wr_advance, rd_valid, op_done, op_error;
    logic [15:0]       rd_data;
    logic [1:0]        ctrl_command;
    logic [21:0]       ctrl_address;
    logic [15:0]       ctrl_write_data;
    logic [15:0]       ctrl_data_read = 16'h0;
    logic              ctrl_data_read_valid = 1'b0;
    logic              ctrl_data_write_done = 1'b0;

    always #5 clk = ~clk;

    sdram_arbiter #(.NUM_PORTS(N), .TIMEOUT_CYCLES(T), .SETTLE_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_command(req_command), .req_address(req_address),
        .req_write_data(req_write_data),
        .grant(grant), .wr_advance(wr_advance), .rd_valid(rd_valid),
        .rd_data(rd_data), .op_done(op_done), .op_error(op_error),
        .ctrl_command(ctrl_command), .ctrl_address(ctrl_address),
        .ctrl_write_data(ctrl_write_data), .ctrl_data_read(ctrl_data_read),
        .ctrl_data_read_valid(ctrl_data_read_valid),
        .ctrl_data_write_done(ctrl_data_write_done)
    );

    // Controller model: accepts a command when idle, waits m_delay+1 cycles,
    // emits BL beats, then needs one idle cycle before it samples again.
    int          m_en = 1, m_bl = 1, m_delay = 0, m_ops = 0;
    int          m_state = 0, m_wait = 0, m_idx = 0, m_left = 0;
    logic [1:0]  m_cmd = 2'd0;
    logic [21:0] m_addr = 22'h0;

    always @(negedge clk) begin
        ctrl_data_read_valid = 1'b0;
        ctrl_data_write_done = 1'b0;
        case (m_state)
            0: if (m_en != 0 && ctrl_command != 2'd0) begin
                m_cmd = ctrl_command; m_addr = ctrl_address;
                m_wait = m_delay + 1; m_idx = 0; m_left = m_bl;
                m_ops++; m_state = 1;
            end
            1: begin
                m_wait--;
                if (m_wait == 0) m_state = 2;
            end
            2: begin
                if (m_cmd == 2'd2) begin
                    ctrl_data_read_valid = 1'b1;
                    ctrl_data_read = m_addr[15:0] + 16'(m_idx);
                end else begin
                    ctrl_data_write_done = 1'b1;
                end
                m_idx++;
                if (m_idx == m_left) m_state = 3;
            end
            default: m_state = 0;
        endcase
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    typedef struct {
        int          port;
        logic [1:0]  cmd;
        logic [21:0] addr;
        logic [15:0] wdata;
        int          bl;
        int          delay;
        int          exp_lat;
        int          exp_cmdc;
        int          exp_rd;
        int          exp_wr;
        logic [15:0] exp_rd0;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int k, lat, cmdc, rdn, wrn, addr_bad, ops0;
        logic [15:0] wd;
        wd = v.wdata;
        m_bl = v.bl; m_delay = v.delay; ops0 = m_ops;
        req_command[2*v.port +: 2]     = v.cmd;
        req_address[22*v.port +: 22]   = v.addr;
        req_write_data[16*v.port +: 16] = wd;
        k = 0;
        do begin step(); k++; end while (grant == '0 && k < 50);
        check("grant_latency", 32'(k), 32'd1);
        check("grant", 32'(grant), 32'(1 << v.port));
        check("ctrl_command", 32'(ctrl_command), 32'(v.cmd));
        check("ctrl_address", 32'(ctrl_address), 32'(v.addr));
        lat = 0; cmdc = 0; rdn = 0; wrn = 0; addr_bad = 0;
        while (op_done == '0 && lat < 200) begin
            if (ctrl_command != 2'd0) cmdc++;
            if (ctrl_address !== v.addr) addr_bad++;
            if (rd_valid != '0) begin
                check("rd_valid", 32'(rd_valid), 32'(1 << v.port));
                check("rd_data", 32'(rd_data), 32'(v.exp_rd0 + 16'(rdn)));
                rdn++;
            end
            if (wr_advance != '0) begin
                check("wr_advance", 32'(wr_advance), 32'(1 << v.port));
                check("ctrl_write_data", 32'(ctrl_write_data), 32'(wd));
                wrn++;
                wd = wd + 16'h1111;
                req_write_data[16*v.port +: 16] = wd;
            end
            req_address[22*v.port +: 22] = ~v.addr;
            step();
            lat++;
        end
        check("done_latency", 32'(lat), 32'(v.exp_lat));
        check("op_done", 32'(op_done), 32'(1 << v.port));
        check("op_error", 32'(op_error), 32'd0);
        check("grant_released", 32'(grant), 32'd0);
        check("cmd_cycles", 32'(cmdc), 32'(v.exp_cmdc));
        check("rd_beats", 32'(rdn), 32'(v.exp_rd));
        check("wr_beats", 32'(wrn), 32'(v.exp_wr));
        check("addr_stable", 32'(addr_bad), 32'd0);
        check("ops_issued", 32'(m_ops - ops0), 32'd1);
        check("wdata_idle", 32'(ctrl_write_data), 32'd0);
        req_command[2*v.port +: 2] = 2'd0;
    endtask

    initial begin
        int k, lat, leak, exp_port;
        logic [N-1:0] last_grant;
        vecs[0] = '{1, 2'd2, 22'h012345, 16'h0000, 1, 0,  5,  3, 1, 0, 16'h2345};
        vecs[1] = '{2, 2'd1, 22'h00ABCD, 16'h1000, 4, 0,  8,  3, 0, 4, 16'h0000};
        vecs[2] = '{0, 2'd2, 22'h3FFFFF, 16'h0000, 1, 10, 15, 13, 1, 0, 16'hFFFF};
        vecs[3] = '{3, 2'd1, 22'h000000, 16'hBEEF, 2, 0,  6,  3, 0, 2, 16'h0000};
        vecs[4] = '{3, 2'd2, 22'h2A5A5A, 16'h0000, 4, 2, 10,  5, 4, 0, 16'h5A5A};

        reset_n = 1'b0;
        req_command = '0; req_address = '0; req_write_data = '0;
        step(); step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_cmd", 32'(ctrl_command), 32'd0);
        check("rst_addr", 32'(ctrl_address), 32'd0);
        check("rst_done", 32'({op_done, op_error}), 32'd0);
        check("rst_wdata", 32'(ctrl_write_data), 32'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) step();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Controller never answers: abort, resettle, then serve port 1.
        m_en = 0; m_bl = 1; m_delay = 0;
        req_command[1:0] = 2'd2; req_address[21:0] = 22'h000100;
        k = 0;
        do begin step(); k++; end while (grant == '0 && k < 50);
        check("to_grant", 32'(grant), 32'd1);
        req_command[3:2] = 2'd2; req_address[43:22] = 22'h000200;
        lat = 0;
        while (op_done == '0 && lat < T + 50) begin step(); lat++; end
        check("to_latency", 32'(lat), 32'(T));
        check("to_done", 32'(op_done), 32'd1);
        check("to_error", 32'(op_error), 32'd1);
        check("to_cmd", 32'(ctrl_command), 32'd0);
        check("to_grant_clr", 32'(grant), 32'd0);
        req_command[1:0] = 2'd0;
        m_en = 1;
        k = 0;
        while (grant == '0 && k < 60) begin step(); k++; end
        check("to_settle", 32'(k), 32'd17);
        check("to_next_grant", 32'(grant), 32'd2);
        lat = 0;
        while (op_done == '0 && lat < 50) begin step(); lat++; end
        check("to_next_done", 32'({op_error, op_done}), 32'h02);
        req_command[3:2] = 2'd0;

        // Reset lands in the middle of an 8-beat read.
        m_bl = 8; m_delay = 0;
        req_command[5:4] = 2'd2; req_address[65:44] = 22'h000300;
        k = 0;
        do begin step(); k++; end while (grant == '0 && k < 50);
        check("rb_grant", 32'(grant), 32'd4);
        k = 0;
        while (rd_valid == '0 && k < 20) begin step(); k++; end
        check("rb_first_beat", 32'(rd_valid), 32'd4);
        reset_n = 1'b0;
        #1;
        check("rb_async", 32'({grant, ctrl_command, op_done}), 32'd0);
        req_command = '0;
        m_bl = 1;
        step();
        check("rb_beat_blocked", 32'({ctrl_data_read_valid, rd_valid}), 32'h10);
        step();
        reset_n = 1'b1;
        req_command = 8'b01010101;
        k = 0; leak = 0;
        while (grant == '0 && k < 60) begin
            if (rd_valid != '0) leak++;
            step(); k++;
        end
        check("rb_quiet_wait", 32'(k), 32'd23);
        check("rb_no_leak", 32'(leak), 32'd0);

        // All four ports write continuously: strict rotation.
        for (int g = 0; g < 5; g++) begin
            exp_port = g % N;
            check("rr_grant", 32'(grant), 32'(1 << exp_port));
            last_grant = grant;
            lat = 0;
            while (op_done == '0 && lat < 50) begin step(); lat++; end
            check("rr_done", 32'({grant, op_done}), 32'(last_grant));
            if (g == 4) begin
                req_command = '0;
            end else begin
                k = 0;
                do begin step(); k++; end while (grant == '0 && k < 10);
                check("rr_gap", 32'(k), 32'd1);
            end
        end
        for (int i = 0; i < 5; i++) step();
        check("final_idle", 32'({grant, ctrl_command}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
Round-robin arbiter that shares one as4c4m16sa SDRAM controller between NUM_PORTS requesters. It latches the winning request and drives the controller's command/address inputs. It infers operation progress from data_read_valid / data_write_done, because the controller has no ready/busy output, and it routes read data and per-port completion pulses back to the requesters. It sits between client blocks (e.g. video framebuffer, CPU bridge) and the controller instance.

Parameters:
NUM_PORTS, 4, number of requesters (2..8)
TIMEOUT_CYCLES, 4096, max cycles from grant to completion before abort
SETTLE_CYCLES, 16, consecutive quiet cycles required after reset before first grant

Ports:
clk  in  1  system clock (same clock as controller)
reset_n  in  1  asynchronous active-low reset
req_command  in  2*NUM_PORTS  per-port command: 0 idle, 1 write, 2 read, 3 treated as idle
req_address  in  22*NUM_PORTS  per-port word address
req_write_data  in  16*NUM_PORTS  per-port write data
grant  out  NUM_PORTS  one-hot owner of controller, 0 when none
wr_advance  out  NUM_PORTS  grant[i] & ctrl_data_write_done; requester presents next burst word
rd_valid  out  NUM_PORTS  grant[i] & ctrl_data_read_valid
rd_data  out  16  ctrl_data_read broadcast
op_done  out  NUM_PORTS  1-cycle pulse at end of port's operation
op_error  out  NUM_PORTS  1-cycle pulse coincident with op_done on timeout abort
ctrl_command  out  2  to controller command
ctrl_address  out  22  to controller data_address
ctrl_write_data  out  16  to controller data_write
ctrl_data_read  in  16  from controller
ctrl_data_read_valid  in  1  from controller
ctrl_data_write_done  in  1  from controller

Behaviour:
- Reset (async, reset_n=0): state SETTLE, grant=0, ctrl_command=0, ctrl_address=0, op_done=0, op_error=0, rr pointer=NUM_PORTS-1 (port 0 has first priority), quiet/timeout counters=0.
- SETTLE: count cycles with ctrl_data_read_valid=0 and ctrl_data_write_done=0; any high restarts count; at SETTLE_CYCLES go IDLE. This discards beats of an operation in flight across reset (the controller has no reset).
- IDLE: a port is requesting if req_command is 1 or 2. Choose the first requester searching from pointer+1 modulo NUM_PORTS. Next cycle (1-cycle latency): grant one-hot, ctrl_command and ctrl_address registered from that port's inputs, op type latched, go ISSUE. No requester: stay IDLE, outputs 0.
- ISSUE: hold ctrl_command/ctrl_address. Leave on first beat: write op and ctrl_data_write_done=1, or read op and ctrl_data_read_valid=1. Then ctrl_command<=0 (prevents re-issue when the controller returns to idle) and go BURST. The controller may refresh before accepting; holding the command covers this.
- BURST: ctrl_command=0, ctrl_address still held (controller reads it during the op). When both ctrl_data_read_valid=0 and ctrl_data_write_done=0, go RELEASE.
- RELEASE: op_done[owner]=1 for one cycle, grant<=0, pointer<=owner, go IDLE. Earliest next grant is the following cycle; the controller samples the new command only once it is back to idle.
- Latched command/address ignore requester changes after grant. Write data is live: ctrl_write_data = req_write_data of granted port (combinational mux), 0 when no grant. A requester must keep req_command asserted until op_done, or drop it in the op_done cycle to avoid re-request.
- Timeout: counter runs in ISSUE and BURST, cleared on grant. At TIMEOUT_CYCLES: ctrl_command<=0, op_done[owner] and op_error[owner] pulse, grant<=0, pointer<=owner, go SETTLE.
- rd_valid/wr_advance/rd_data are combinational from registered grant and controller outputs; all other outputs are registered.
- Invariants: grant at most one-hot; ctrl_command nonzero only in ISSUE; op_done at most one bit per cycle.

Test Plan:
- Single port 1 reads 0x12345 (controller model BL=1, CL=2) -> grant=0b0010 one cycle after request, ctrl_command=2 until valid, rd_valid[1] 1 cycle with model data, op_done[1] pulse, ctrl_command never re-asserted.
- Ports 0..3 all request writes continuously -> grants in order 0,1,2,3,0; each op_done precedes the next grant; no port is granted twice in a row while others wait.
- Burst write BL=4 on port 2 -> wr_advance[2] high 4 cycles, ctrl_write_data tracks port-2 data, ctrl_address stays stable while req_address changes mid-op.
- Controller model refreshes (delays first beat 10 cycles) -> ctrl_command held 2 through delay, single operation observed.
- Model never responds -> after 4096 cycles op_done[0]&op_error[0] pulse, ctrl_command=0, SETTLE then port 1 granted.
- reset_n asserted mid-read burst -> outputs 0 immediately; trailing rd_valid beats not forwarded; no grant until 16 quiet cycles.
